// File: rtl/staggered_add_collector.sv
// Collects {CO,S} from a fixed-latency adder LAT cycles after each accepted issue and buffers
// the results in a credit-protected FIFO with a valid/ready output port.
module staggered_add_collector #(
    parameter int unsigned N     = 16,
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SEQW  = 8
) (
    input  logic                         Clock,
    input  logic                         ResetN,
    input  logic                         InValid,
    output logic                         InReady,
    input  logic [N-1:0]                 S,
    input  logic                         CO,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic [N:0]                   OutSum,
    output logic [SEQW-1:0]              OutSeq,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         DropErr
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    // Issue-tracking delay line: valid bit and sequence tag per adder stage
    logic [LAT-1:0]  vld_q, vld_d;
    logic [SEQW-1:0] tag_q [LAT];
    logic [SEQW-1:0] tag_d [LAT];
    logic [SEQW-1:0] seq_q, seq_d;

    // Result FIFO
    logic [N:0]      sum_mem_q [DEPTH];
    logic [SEQW-1:0] seq_mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] occ_q, occ_d;

    // In-flight plus buffered results; the credit pool
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drop_q, drop_d;

    logic issue;
    logic cap;
    logic pop;

    always_comb begin
        InReady  = cnt_q < DepthC;
        OutValid = occ_q != '0;
        issue    = InValid & InReady;
        cap      = vld_q[LAT-1];
        pop      = OutValid & OutReady;

        vld_d    = '0;
        vld_d[0] = issue;
        tag_d[0] = seq_q;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
        end

        seq_d    = issue ? seq_q + SEQW'(1) : seq_q;
        wr_ptr_d = wr_ptr_q + PtrW'(cap);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        occ_d    = occ_q + CntW'(cap) - CntW'(pop);
        cnt_d    = cnt_q + CntW'(issue) - CntW'(pop);
        drop_d   = drop_q | (InValid & ~InReady);
    end

    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            vld_q    <= '0;
            seq_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            drop_q   <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            seq_q    <= seq_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

    // Storage is cleared on reset so the head reads as zero rather than X while empty
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                sum_mem_q[i] <= '0;
                seq_mem_q[i] <= '0;
            end
        end else if (cap) begin
            sum_mem_q[wr_ptr_q] <= {CO, S};
            seq_mem_q[wr_ptr_q] <= tag_q[LAT-1];
        end
    end

    assign OutSum  = sum_mem_q[rd_ptr_q];
    assign OutSeq  = seq_mem_q[rd_ptr_q];
    assign Count   = cnt_q;
    assign DropErr = drop_q;

    // Credits are reserved at issue, so a capture must always find a free slot
    a_cap_not_full : assert property (@(posedge Clock) disable iff (!ResetN)
        cap |-> (occ_q != DepthC))
        else $error("capture attempted into a full result buffer");

    a_cnt_bound : assert property (@(posedge Clock) disable iff (!ResetN)
        (cnt_q <= DepthC) && (occ_q <= cnt_q))
        else $error("credit count out of range");

endmodule

// File: tb/tb_staggered_add_collector.sv
// Scoreboard bench for staggered_add_collector: a behavioural LAT-stage adder feeds S/CO,
// issues push expected results, a negedge monitor pops and compares on output handshakes.
module tb_staggered_add_collector;

    localparam int unsigned N     = 16;
    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned SEQW  = 8;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [N:0]      sum;
        logic [SEQW-1:0] seq;
    } res_t;

    logic            Clock = 1'b0;
    logic            ResetN = 1'b0;
    logic            InValid = 1'b0;
    logic            InReady;
    logic [N-1:0]    S;
    logic            CO;
    logic            OutValid;
    logic            OutReady = 1'b0;
    logic [N:0]      OutSum;
    logic [SEQW-1:0] OutSeq;
    logic [CntW-1:0] Count;
    logic            DropErr;

    logic [N-1:0]    A = '0;
    logic [N-1:0]    B = '0;
    logic            CI = 1'b0;
    logic [N:0]      exp_in = '0;

    int total = 0;
    int bad = 0;

    res_t            sb[$];
    int              m_cnt = 0;
    logic [SEQW-1:0] m_seq = '0;
    logic            m_drop = 1'b0;
    logic            pop_pend = 1'b0;
    logic            chk_en = 1'b0;

    staggered_add_collector #(
        .N     (N),
        .LAT   (LAT),
        .DEPTH (DEPTH),
        .SEQW  (SEQW)
    ) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .InValid  (InValid),
        .InReady  (InReady),
        .S        (S),
        .CO       (CO),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutSum   (OutSum),
        .OutSeq   (OutSeq),
        .Count    (Count),
        .DropErr  (DropErr)
    );

    always #5 Clock = ~Clock;

    // Behavioural adder with LAT cycles of latency
    logic [N:0] add_pipe [LAT];
    always @(posedge Clock) begin
        add_pipe[0] <= {1'b0, A} + {1'b0, B} + {{N{1'b0}}, CI};
        for (int i = 1; i < LAT; i++) begin
            add_pipe[i] <= add_pipe[i-1];
        end
    end
    assign S  = add_pipe[LAT-1][N-1:0];
    assign CO = add_pipe[LAT-1][N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: credit count, sequence counter, sticky drop flag, expected results
    always @(posedge Clock) begin
        logic acc;
        if (!ResetN) begin
            sb.delete();
            m_cnt  = 0;
            m_seq  = '0;
            m_drop = 1'b0;
        end else begin
            acc = InValid && (m_cnt < DEPTH);
            if (InValid && !acc) m_drop = 1'b1;
            if (acc) begin
                sb.push_back('{sum: exp_in, seq: m_seq});
                m_seq = m_seq + 1'b1;
            end
            m_cnt = m_cnt + int'(acc) - int'(pop_pend);
        end
    end

    // Monitor: continuous flag checks plus head comparison on every valid cycle
    always @(negedge Clock) begin
        res_t h;
        pop_pend = 1'b0;
        if (ResetN && chk_en) begin
            check("count", 32'(Count), 32'(m_cnt));
            check("in_ready", 32'(InReady), 32'(m_cnt < DEPTH));
            check("drop_err", 32'(DropErr), 32'(m_drop));
            if (OutValid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: sum=%0h seq=%0h, expected no output (t=%0t)",
                             OutSum, OutSeq, $time);
                    pop_pend = OutReady;
                end else begin
                    h = sb[0];
                    check("out_sum", 32'(OutSum), 32'(h.sum));
                    check("out_seq", 32'(OutSeq), 32'(h.seq));
                    if (OutReady) begin
                        void'(sb.pop_front());
                        pop_pend = 1'b1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic ci, input logic [N:0] e);
        InValid = v;
        A       = a;
        B       = b;
        CI      = ci;
        exp_in  = e;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        idle();
        ResetN = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_out_sum", 32'(OutSum), 32'd0);
        check("rst_out_seq", 32'(OutSeq), 32'd0);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_drop_err", 32'(DropErr), 32'd0);
        check("rst_in_ready", 32'(InReady), 32'd1);
        ResetN = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d results pending, expected 0", sb.size());
        end
        tick();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();

        // Single issue: 7+9+1 = 17, visible exactly LAT edges later
        OutReady = 1'b1;
        drive(1'b1, 16'd7, 16'd9, 1'b1, 17'd17);
        tick();
        idle();
        check("lat_edge1_valid", 32'(OutValid), 32'd0);
        tick();
        check("lat_edge2_valid", 32'(OutValid), 32'd0);
        tick();
        check("lat_edge3_valid", 32'(OutValid), 32'd1);
        check("lat_head_sum", 32'(OutSum), 32'd17);
        tick();
        check("post_pop_count", 32'(Count), 32'd0);
        drain();

        // Full sweep issued every cycle; sequence wraps after 256
        do_reset();
        OutReady = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive(1'b1, 16'(a), 16'(b), 1'(c), 17'(a + b + c));
                    tick();
                end
            end
        end
        idle();
        drain();

        // Carry-out captured
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b1, 17'h10001);
        tick();
        idle();
        drain();

        // Stalled consumer: only DEPTH issues accepted, extra attempts set DropErr
        OutReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'(i + 1), 16'(i * 3), 1'b0, 17'(4 * i + 1));
            tick();
        end
        idle();
        check("stall_count", 32'(Count), 32'd4);
        check("stall_in_ready", 32'(InReady), 32'd0);
        check("stall_drop_err", 32'(DropErr), 32'd1);
        repeat (4) tick();
        OutReady = 1'b1;
        tick();
        check("pop_frees_credit", 32'(InReady), 32'd1);
        drain();
        check("drop_sticky", 32'(DropErr), 32'd1);

        // Sequence unaffected by rejected issues
        drive(1'b1, 16'd100, 16'd200, 1'b0, 17'd300);
        tick();
        idle();
        drain();

        // Reset with one buffered and two in flight
        OutReady = 1'b0;
        drive(1'b1, 16'd1, 16'd1, 1'b0, 17'd2);
        tick();
        drive(1'b1, 16'd2, 16'd2, 1'b0, 17'd4);
        tick();
        drive(1'b1, 16'd3, 16'd3, 1'b0, 17'd6);
        tick();
        check("mid_buffered_valid", 32'(OutValid), 32'd1);
        check("mid_count", 32'(Count), 32'd3);
        idle();
        ResetN = 1'b0;
        tick();
        check("mid_rst_valid", 32'(OutValid), 32'd0);
        check("mid_rst_count", 32'(Count), 32'd0);
        check("mid_rst_drop", 32'(DropErr), 32'd0);
        ResetN = 1'b1;
        OutReady = 1'b1;
        repeat (LAT + 4) tick();
        check("no_stale_valid", 32'(OutValid), 32'd0);
        drive(1'b1, 16'd40, 16'd2, 1'b1, 17'd43);
        tick();
        idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
